// File: rtl/regfile_read_stage.sv
// Register-file read stage: two 32:1 operand selects registered into the ID/EX boundary
// with valid/stall/flush control. Define REGREAD_BYPASS_EN to forward a same-cycle write.
module regfile_read_stage #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [32*WIDTH-1:0] regs,
    input  logic [4:0]          ReadRegister1,
    input  logic [4:0]          ReadRegister2,
    input  logic                in_valid,
    input  logic                stall,
    input  logic                flush,
    input  logic [4:0]          WriteRegister,
    input  logic [WIDTH-1:0]    WriteData,
    input  logic                RegWrite,
    output logic [WIDTH-1:0]    ReadData1,
    output logic [WIDTH-1:0]    ReadData2,
    output logic                out_valid
);

    localparam logic [4:0] ZERO_ADDR = 5'(ZERO_REG);

    logic [WIDTH-1:0] reg_arr [32];

    for (genvar i = 0; i < 32; i++) begin : g_unpack
        assign reg_arr[i] = regs[WIDTH*i +: WIDTH];
    end

    logic [WIDTH-1:0] sel1, sel2;
    logic             hit1, hit2;

`ifdef REGREAD_BYPASS_EN
    assign hit1 = RegWrite && (WriteRegister == ReadRegister1) && (ReadRegister1 != ZERO_ADDR);
    assign hit2 = RegWrite && (WriteRegister == ReadRegister2) && (ReadRegister2 != ZERO_ADDR);
`else
    // Forwarding disabled: the writeback inputs are intentionally left unconsumed.
    logic unused_wb;
    assign unused_wb = ^{WriteRegister, WriteData, RegWrite};
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    always_comb begin
        sel1 = reg_arr[ReadRegister1];
        sel2 = reg_arr[ReadRegister2];
        if (hit1) sel1 = WriteData;
        if (hit2) sel2 = WriteData;
        // XZR wins over both the array contents and any forwarded write.
        if (ReadRegister1 == ZERO_ADDR) sel1 = '0;
        if (ReadRegister2 == ZERO_ADDR) sel2 = '0;
    end

    logic [WIDTH-1:0] rd1_d, rd1_q;
    logic [WIDTH-1:0] rd2_d, rd2_q;
    logic             vld_d, vld_q;

    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        vld_d = vld_q;
        if (flush) begin
            rd1_d = '0;
            rd2_d = '0;
            vld_d = 1'b0;
        end else if (!stall) begin
            vld_d = in_valid;
            if (in_valid) begin
                rd1_d = sel1;
                rd2_d = sel2;
            end
        end
    end

    // ID/EX boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd1_q <= '0;
            rd2_q <= '0;
            vld_q <= 1'b0;
        end else begin
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
            vld_q <= vld_d;
        end
    end

    assign ReadData1 = rd1_q;
    assign ReadData2 = rd2_q;
    assign out_valid = vld_q;

endmodule
